// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states, data width.
// Optional misalignment trapping in lsu is enabled by defining LSU_MISALIGN_CHECK_EN.
package lsu_pkg;

  localparam int WORD_DATA = 32;

  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;

  localparam logic [1:0] LSU_SIZE_B = 2'b00;
  localparam logic [1:0] LSU_SIZE_H = 2'b01;
  localparam logic [1:0] LSU_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_e;

  // True for accesses the bus cannot carry in one naturally aligned beat.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      LSU_SIZE_B: is_misaligned = DISABLE;
      LSU_SIZE_H: is_misaligned = a[0];
      LSU_SIZE_W: is_misaligned = (a != 2'b00);
      default:    is_misaligned = ENABLE;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane alignment: store byte enables / replicated write data, and load
// lane extraction with sign or zero extension. Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]           st_size,
  input  logic [1:0]           st_addr,
  input  logic [WORD_DATA-1:0] st_wdata,
  output logic [3:0]           be,
  output logic [WORD_DATA-1:0] wdata,
  input  logic [1:0]           ld_size,
  input  logic [1:0]           ld_addr,
  input  logic                 ld_unsigned,
  input  logic [WORD_DATA-1:0] rdata,
  output logic [WORD_DATA-1:0] ld_data
);

  logic [WORD_DATA-1:0] byte_sh;
  logic [WORD_DATA-1:0] half_sh;

  // Misaligned halves/words fall through to the aligned lane because the
  // low address bits are simply not used for those sizes.
  always_comb begin
    be    = 4'b1111;
    wdata = st_wdata;
    case (st_size)
      LSU_SIZE_B: begin
        be    = 4'b0001 << st_addr;
        wdata = {4{st_wdata[7:0]}};
      end
      LSU_SIZE_H: begin
        be    = 4'b0011 << {st_addr[1], 1'b0};
        wdata = {2{st_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign byte_sh = rdata >> {ld_addr, 3'b000};
  assign half_sh = rdata >> {ld_addr[1], 4'b0000};

  always_comb begin
    ld_data = rdata;
    case (ld_size)
      LSU_SIZE_B: ld_data = ld_unsigned ? {24'b0, byte_sh[7:0]}
                                        : {{24{byte_sh[7]}}, byte_sh[7:0]};
      LSU_SIZE_H: ld_data = ld_unsigned ? {16'b0, half_sh[15:0]}
                                        : {{16{half_sh[15]}}, half_sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one access at a time over a req/ack bus, IDLE -> BUS -> RESP.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned or reserved-size accesses.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [1:0]           lsu_size,
  input  logic                 lsu_unsigned,
  input  logic [WORD_DATA-1:0] lsu_addr,
  input  logic [WORD_DATA-1:0] lsu_wdata,
  output logic                 lsu_busy,
  output logic                 lsu_done,
  output logic [WORD_DATA-1:0] lsu_rdata,
  output logic                 lsu_err,
  output logic                 bus_req,
  output logic                 bus_we,
  output logic [WORD_DATA-1:0] bus_addr,
  output logic [3:0]           bus_be,
  output logic [WORD_DATA-1:0] bus_wdata,
  input  logic [WORD_DATA-1:0] bus_rdata,
  input  logic                 bus_ack,
  output lsu_state_e           state
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  lsu_state_e           next_state;
  logic [7:0]           tmo_cnt;
  logic                 err_q;
  logic [1:0]           size_q;
  logic [1:0]           addr_lo_q;
  logic                 unsigned_q;
  logic [3:0]           be_next;
  logic [WORD_DATA-1:0] wdata_next;
  logic [WORD_DATA-1:0] ld_data;
  logic                 misalign;
  logic                 tmo_hit;

`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = is_misaligned(lsu_size, lsu_addr[1:0]);
`else
  assign misalign = DISABLE;
`endif

  assign tmo_hit = (tmo_cnt == TIMEOUT_LIMIT);

  lsu_align u_align (
    .st_size     (lsu_size),
    .st_addr     (lsu_addr[1:0]),
    .st_wdata    (lsu_wdata),
    .be          (be_next),
    .wdata       (wdata_next),
    .ld_size     (size_q),
    .ld_addr     (addr_lo_q),
    .ld_unsigned (unsigned_q),
    .rdata       (bus_rdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: if (lsu_req) next_state = misalign ? ST_RESP : ST_BUS;
      ST_BUS:  if (bus_ack || tmo_hit) next_state = ST_RESP;
      ST_RESP: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Request fields are latched on accept so bus outputs stay stable until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_we     <= DISABLE;
      bus_addr   <= '0;
      bus_be     <= '0;
      bus_wdata  <= '0;
      lsu_rdata  <= '0;
      tmo_cnt    <= '0;
      err_q      <= DISABLE;
      size_q     <= '0;
      addr_lo_q  <= '0;
      unsigned_q <= DISABLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (lsu_req) begin
            bus_we     <= lsu_we;
            bus_addr   <= {lsu_addr[WORD_DATA-1:2], 2'b00};
            bus_be     <= be_next;
            bus_wdata  <= wdata_next;
            size_q     <= lsu_size;
            addr_lo_q  <= lsu_addr[1:0];
            unsigned_q <= lsu_unsigned;
            tmo_cnt    <= '0;
            err_q      <= misalign;
          end
        end
        ST_BUS: begin
          if (bus_ack) begin
            if (!bus_we) lsu_rdata <= ld_data;
          end else if (tmo_hit) begin
            err_q <= ENABLE;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        ST_RESP: begin
          err_q   <= DISABLE;
          tmo_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus_req  = (state == ST_BUS);
  assign lsu_busy = (state != ST_IDLE);
  assign lsu_done = (state == ST_RESP);
  assign lsu_err  = lsu_done && err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu with TIMEOUT_CYCLES = 4; expected values are hand-computed.
module tb_lsu;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_unsigned = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_busy, lsu_done, lsu_err, bus_req, bus_we;
  logic [31:0] lsu_rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  lsu_state_e  state;

  int checks = 0;
  int errors = 0;

  lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack), .state(state)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents a request for one edge; returns 1 time unit after the accepting edge.
  task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata);
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = wdata;
    step();
    lsu_req = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", state, ST_IDLE); end
    checks++; if ({lsu_busy, lsu_done, lsu_err, bus_req, bus_we} !== 5'b0) begin errors++; $display("FAIL reset_flags: got %b expected 00000", {lsu_busy, lsu_done, lsu_err, bus_req, bus_we}); end
    checks++; if (lsu_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", lsu_rdata); end
    checks++; if ({bus_addr, bus_be, bus_wdata} !== 68'h0) begin errors++; $display("FAIL reset_bus: got %h %b %h expected zeros", bus_addr, bus_be, bus_wdata); end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_loads();
    logic [31:0] t_addr  [6] = '{32'h103, 32'h103, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [1:0]  t_size  [6] = '{LSU_SIZE_B, LSU_SIZE_B, LSU_SIZE_H, LSU_SIZE_H, LSU_SIZE_B, LSU_SIZE_W};
    logic        t_uns   [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [3:0]  t_be    [6] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b0010, 4'b1111};
    logic [31:0] t_rdata [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80AA, 32'h0000_BBCC, 32'hFFFF_FFBB, 32'h80AA_BBCC};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, t_size[i], t_uns[i], t_addr[i], 32'h0);
      checks++; if ({bus_req, bus_we, lsu_done} !== 3'b100) begin errors++; $display("FAIL load%0d_bus_ctl: got %b expected 100", i, {bus_req, bus_we, lsu_done}); end
      checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL load%0d_addr: got %h expected 00000100", i, bus_addr); end
      checks++; if (bus_be !== t_be[i]) begin errors++; $display("FAIL load%0d_be: got %b expected %b", i, bus_be, t_be[i]); end
      bus_ack = 1'b1; bus_rdata = 32'h80AA_BBCC;
      step();
      bus_ack = 1'b0;
      checks++; if ({lsu_done, lsu_err} !== 2'b10) begin errors++; $display("FAIL load%0d_done: got %b expected 10", i, {lsu_done, lsu_err}); end
      checks++; if (lsu_rdata !== t_rdata[i]) begin errors++; $display("FAIL load%0d_rdata: got %h expected %h", i, lsu_rdata, t_rdata[i]); end
      step();
      checks++; if ({lsu_busy, lsu_done} !== 2'b00) begin errors++; $display("FAIL load%0d_idle: got %b expected 00", i, {lsu_busy, lsu_done}); end
    end
  endtask

  task automatic test_stores();
    logic [31:0] t_addr  [3] = '{32'h202, 32'h301, 32'h300};
    logic [1:0]  t_size  [3] = '{LSU_SIZE_H, LSU_SIZE_B, LSU_SIZE_W};
    logic [31:0] t_wdata [3] = '{32'h1234_5678, 32'h0000_00AB, 32'hCAFE_F00D};
    logic [31:0] t_baddr [3] = '{32'h200, 32'h300, 32'h300};
    logic [3:0]  t_be    [3] = '{4'b1100, 4'b0010, 4'b1111};
    logic [31:0] t_bwd   [3] = '{32'h5678_5678, 32'hABAB_ABAB, 32'hCAFE_F00D};
    for (int i = 0; i < 3; i++) begin
      issue(1'b1, t_size[i], 1'b0, t_addr[i], t_wdata[i]);
      checks++; if ({bus_req, bus_we} !== 2'b11) begin errors++; $display("FAIL store%0d_ctl: got %b expected 11", i, {bus_req, bus_we}); end
      checks++; if (bus_addr !== t_baddr[i] || bus_be !== t_be[i]) begin errors++; $display("FAIL store%0d_addr_be: got %h %b expected %h %b", i, bus_addr, bus_be, t_baddr[i], t_be[i]); end
      checks++; if (bus_wdata !== t_bwd[i]) begin errors++; $display("FAIL store%0d_wdata: got %h expected %h", i, bus_wdata, t_bwd[i]); end
      bus_ack = 1'b1; bus_rdata = 32'h5555_AAAA;
      step();
      bus_ack = 1'b0;
      checks++; if (lsu_done !== 1'b1 || lsu_rdata !== 32'h80AA_BBCC) begin errors++; $display("FAIL store%0d_done_rdata: got %b %h expected 1 80aabbcc", i, lsu_done, lsu_rdata); end
      step();
    end
  endtask

  task automatic test_wait_states();
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h40, 32'h0);
    bus_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      checks++; if ({bus_req, bus_we, lsu_done} !== 3'b100 || bus_addr !== 32'h40 || bus_be !== 4'b1111) begin errors++; $display("FAIL wait_cycle%0d: got %b %h %b expected 100 00000040 1111", i, {bus_req, bus_we, lsu_done}, bus_addr, bus_be); end
      if (i == 3) bus_ack = 1'b1;
      step();
    end
    bus_ack = 1'b0;
    checks++; if ({lsu_done, lsu_err, bus_req} !== 3'b100) begin errors++; $display("FAIL wait_done: got %b expected 100", {lsu_done, lsu_err, bus_req}); end
    checks++; if (lsu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wait_rdata: got %h expected deadbeef", lsu_rdata); end
    step();
  endtask

  task automatic test_timeout();
    int n = 1;
    int req_cycles = 0;
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h50, 32'h0);
    while (!lsu_done && n < 20) begin
      if (bus_req) req_cycles++;
      step();
      n++;
    end
    checks++; if (n !== 6) begin errors++; $display("FAIL timeout_latency: got %0d expected 6", n); end
    checks++; if (req_cycles !== 5) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 5", req_cycles); end
    checks++; if ({lsu_done, lsu_err, bus_req} !== 3'b110) begin errors++; $display("FAIL timeout_flags: got %b expected 110", {lsu_done, lsu_err, bus_req}); end
    checks++; if (lsu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL timeout_rdata: got %h expected deadbeef", lsu_rdata); end
    step();
    checks++; if (state !== ST_IDLE || {lsu_busy, lsu_err} !== 2'b00) begin errors++; $display("FAIL timeout_idle: got %0d %b expected 0 00", state, {lsu_busy, lsu_err}); end
  endtask

  task automatic test_misalign();
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h41, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++; if ({bus_req, lsu_done, lsu_err} !== 3'b011) begin errors++; $display("FAIL misalign_trap: got %b expected 011", {bus_req, lsu_done, lsu_err}); end
    checks++; if (lsu_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_rdata: got %h expected deadbeef", lsu_rdata); end
    step();
`else
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h40 || bus_be !== 4'b1111) begin errors++; $display("FAIL misalign_force: got %b %h %b expected 1 00000040 1111", bus_req, bus_addr, bus_be); end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
    step();
    bus_ack = 1'b0;
    checks++; if ({lsu_done, lsu_err} !== 2'b10 || lsu_rdata !== 32'h0BAD_F00D) begin errors++; $display("FAIL misalign_load: got %b %h expected 10 0badf00d", {lsu_done, lsu_err}, lsu_rdata); end
    step();
`endif
    checks++; if (state !== ST_IDLE) begin errors++; $display("FAIL misalign_idle: got %0d expected 0", state); end
  endtask

  task automatic test_back_to_back();
    lsu_state_e exp_st [5] = '{ST_BUS, ST_RESP, ST_IDLE, ST_BUS, ST_RESP};
    int dones = 0;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = LSU_SIZE_B; lsu_unsigned = 1'b1;
    lsu_addr = 32'h100; bus_ack = 1'b1; bus_rdata = 32'h0000_0011;
    for (int e = 0; e < 5; e++) begin
      step();
      checks++; if (state !== exp_st[e]) begin errors++; $display("FAIL b2b_state%0d: got %0d expected %0d", e, state, exp_st[e]); end
      if (lsu_done) dones++;
      if (e == 1) begin
        checks++; if (lsu_rdata !== 32'h11) begin errors++; $display("FAIL b2b_rdata0: got %h expected 00000011", lsu_rdata); end
        bus_rdata = 32'h0000_0022;
      end
    end
    lsu_req = 1'b0; bus_ack = 1'b0;
    checks++; if (dones !== 2) begin errors++; $display("FAIL b2b_dones: got %0d expected 2", dones); end
    checks++; if (lsu_rdata !== 32'h22) begin errors++; $display("FAIL b2b_rdata1: got %h expected 00000022", lsu_rdata); end
    step();
  endtask

  task automatic test_reset_mid();
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h60, 32'h0);
    step();
    rst = 1'b1; bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    step();
    checks++; if (state !== ST_IDLE || {lsu_busy, lsu_done, lsu_err, bus_req, bus_we} !== 5'b0) begin errors++; $display("FAIL rstmid_flags: got %0d %b expected 0 00000", state, {lsu_busy, lsu_done, lsu_err, bus_req, bus_we}); end
    checks++; if ({lsu_rdata, bus_addr, bus_be, bus_wdata} !== 100'h0) begin errors++; $display("FAIL rstmid_data: got %h %h %b %h expected zeros", lsu_rdata, bus_addr, bus_be, bus_wdata); end
    rst = 1'b0; bus_ack = 1'b0;
    step();
    checks++; if ({lsu_done, lsu_busy} !== 2'b00) begin errors++; $display("FAIL rstmid_nodone: got %b expected 00", {lsu_done, lsu_busy}); end
    issue(1'b0, LSU_SIZE_W, 1'b0, 32'h70, 32'h0);
    checks++; if (bus_req !== 1'b1 || bus_addr !== 32'h70) begin errors++; $display("FAIL rstmid_fresh_bus: got %b %h expected 1 00000070", bus_req, bus_addr); end
    bus_ack = 1'b1; bus_rdata = 32'h1122_3344;
    step();
    bus_ack = 1'b0;
    checks++; if ({lsu_done, lsu_err} !== 2'b10 || lsu_rdata !== 32'h1122_3344) begin errors++; $display("FAIL rstmid_fresh_done: got %b %h expected 10 11223344", {lsu_done, lsu_err}, lsu_rdata); end
    step();
  endtask

  initial begin
    #1;
    test_reset();
    test_loads();
    test_stores();
    test_wait_states();
    test_timeout();
    test_misalign();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
